// File: rtl/nanorisc_pkg.sv
// Shared types and default constants for the NanoRisc fetch stage.
package nanorisc_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned RESET_PC_DEF   = 0;
  localparam int unsigned PROG_LAST_DEF  = 21;

  // RUN fetches, REDIRECT is the single bubble after a taken branch, HALTED is terminal
  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    HALTED
  } fetch_state_e;

  // Next-PC selection driven by the fetch control into the PC register
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_TARGET
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc.sv
// Program-counter register with hold / increment / branch-target next-PC mux.
// Increment wraps modulo 2^ADDR_WIDTH.
module fetch_pc
  import nanorisc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  pc_sel_e               pc_sel,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_q;

  // Select the next PC from the control request
  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_HOLD:   pc_d = pc_q;
      PC_INC:    pc_d = pc_q + ADDR_WIDTH'(1);
      PC_TARGET: pc_d = target;
      default:   pc_d = pc_q;
    endcase
  end

  // PC register, loaded with the boot address on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ADDR_WIDTH'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// NanoRisc instruction-fetch stage: drives the memory address from the PC,
// captures the returned instruction and hands it to decode via valid/ready.
// Optional macro FETCH_BOUNDS_CHECK_EN: a fetch from beyond PROG_LAST raises a
// sticky outFault and halts the stage instead of capturing the instruction.
module fetch_unit
  import nanorisc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RESET_PC   = RESET_PC_DEF,
  parameter int unsigned PROG_LAST  = PROG_LAST_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] outAddress,
  input  logic [DATA_WIDTH-1:0] inInstruction,
  output logic [DATA_WIDTH-1:0] outInstruction,
  output logic [ADDR_WIDTH-1:0] outPC,
  output logic                  outValid,
  input  logic                  inReady,
  input  logic                  inBranchTaken,
  input  logic [ADDR_WIDTH-1:0] inBranchTarget,
  input  logic                  inHalt,
  output logic                  outHalted,
  output logic                  outFault
);

  fetch_state_e          state_d, state_q;
  logic [DATA_WIDTH-1:0] instr_d, instr_q;
  logic [ADDR_WIDTH-1:0] ipc_d, ipc_q;
  logic                  valid_d, valid_q;
  logic                  fault_d, fault_q;
  pc_sel_e               pc_sel;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  load;
  logic                  out_of_bounds;

  fetch_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_fetch_pc (
    .clk    (clock),
    .reset  (reset),
    .pc_sel (pc_sel),
    .target (inBranchTarget),
    .pc     (pc)
  );

  // The instruction register may be refilled when empty or being consumed
  assign load = !valid_q || inReady;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ProgLastAddr = ADDR_WIDTH'(PROG_LAST);
  assign out_of_bounds = (pc > ProgLastAddr);
`else
  logic [ADDR_WIDTH-1:0] unused_prog_last;
  assign unused_prog_last = ADDR_WIDTH'(PROG_LAST);
  assign out_of_bounds    = 1'b0;
`endif

  // Next-state and datapath control: halt beats branch, branch beats stall/advance
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    pc_sel  = PC_HOLD;
    case (state_q)
      RUN, REDIRECT: begin
        if (inHalt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (inBranchTaken) begin
          pc_sel  = PC_TARGET;
          valid_d = 1'b0;
          state_d = REDIRECT;
        end else if (load) begin
          if (out_of_bounds) begin
            valid_d = 1'b0;
            fault_d = 1'b1;
            state_d = HALTED;
          end else begin
            instr_d = inInstruction;
            ipc_d   = pc;
            valid_d = 1'b1;
            pc_sel  = PC_INC;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // Control and instruction-register flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign outAddress     = pc;
  assign outInstruction = instr_q;
  assign outPC          = ipc_q;
  assign outValid       = valid_q;
  assign outHalted      = (state_q == HALTED);
  assign outFault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_fetch_unit;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int unsigned PL = 21;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BoundsOn = 1'b1;
`else
  localparam bit BoundsOn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] outAddress;
  logic [DW-1:0] inInstruction;
  logic [DW-1:0] outInstruction;
  logic [AW-1:0] outPC;
  logic          outValid;
  logic          inReady = 1'b0;
  logic          inBranchTaken = 1'b0;
  logic [AW-1:0] inBranchTarget = '0;
  logic          inHalt = 1'b0;
  logic          outHalted;
  logic          outFault;

  logic [DW-1:0] mem [256];

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural reference state
  logic [AW-1:0] mPc;
  logic [DW-1:0] mInstr;
  logic [AW-1:0] mOpc;
  logic          mValid, mHalted, mFault;

  typedef struct {
    logic          rst, rdy, br;
    logic [AW-1:0] tgt;
    logic          hlt;
    logic          expValid;
    logic [DW-1:0] expInstr;
    logic [AW-1:0] expPc;
    logic [AW-1:0] expAddr;
    logic          expHalted;
  } vec_t;

  vec_t vecs[11];

  always #5 clock = ~clock;

  assign inInstruction = mem[outAddress];

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (0),
    .PROG_LAST  (PL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .outAddress     (outAddress),
    .inInstruction  (inInstruction),
    .outInstruction (outInstruction),
    .outPC          (outPC),
    .outValid       (outValid),
    .inReady        (inReady),
    .inBranchTaken  (inBranchTaken),
    .inBranchTarget (inBranchTarget),
    .inHalt         (inHalt),
    .outHalted      (outHalted),
    .outFault       (outFault)
  );

  function automatic logic [DW-1:0] presetMem(input int a);
    if (a == 0) return 8'h11;
    if (a == 1) return 8'h22;
    if (a == 2) return 8'h33;
    return 8'(a + 64);
  endfunction

  function automatic vec_t mk(input logic rst, rdy, br, input logic [AW-1:0] tgt,
                              input logic hlt, ev, input logic [DW-1:0] ei,
                              input logic [AW-1:0] ep, ea, input logic eh);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.tgt = tgt; v.hlt = hlt;
    v.expValid = ev; v.expInstr = ei; v.expPc = ep; v.expAddr = ea; v.expHalted = eh;
    return v;
  endfunction

  // Spec-level rules for one clock edge
  task automatic modelStep(input logic rst, rdy, br, input logic [AW-1:0] tgt, input logic hlt);
    if (rst) begin
      mPc = '0; mInstr = '0; mOpc = '0; mValid = 1'b0; mHalted = 1'b0; mFault = 1'b0;
    end else if (mHalted) begin
      mHalted = 1'b1;
    end else if (hlt) begin
      mHalted = 1'b1; mValid = 1'b0;
    end else if (br) begin
      mPc = tgt; mValid = 1'b0;
    end else if (!mValid || rdy) begin
      if (BoundsOn && (int'(mPc) > int'(PL))) begin
        mValid = 1'b0; mFault = 1'b1; mHalted = 1'b1;
      end else begin
        mInstr = mem[mPc]; mOpc = mPc; mValid = 1'b1; mPc = mPc + 8'd1;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, rdy, br, input logic [AW-1:0] tgt, input logic hlt);
    @(negedge clock);
    reset = rst; inReady = rdy; inBranchTaken = br; inBranchTarget = tgt; inHalt = hlt;
    modelStep(rst, rdy, br, tgt, hlt);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic [DW-1:0] ei,
                          input logic [AW-1:0] ep, ea, input logic eh, ef);
    checkOutput({tag, ".valid"},  16'(outValid),       16'(ev));
    checkOutput({tag, ".instr"},  16'(outInstruction), 16'(ei));
    checkOutput({tag, ".pc"},     16'(outPC),          16'(ep));
    checkOutput({tag, ".addr"},   16'(outAddress),     16'(ea));
    checkOutput({tag, ".halted"}, 16'(outHalted),      16'(eh));
    checkOutput({tag, ".fault"},  16'(outFault),       16'(ef));
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = presetMem(a);

    // rst rdy br tgt hlt | valid instr pc addr halted
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 8'h00, 8'd0,  8'd0,  1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 8'h11, 8'd0,  8'd1,  1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 8'h22, 8'd1,  8'd2,  1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 8'h22, 8'd1,  8'd2,  1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 8'h22, 8'd1,  8'd2,  1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 8'h22, 8'd1,  8'd2,  1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 8'h33, 8'd2,  8'd3,  1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 8'h33, 8'd2,  8'd10, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 8'h4A, 8'd10, 8'd11, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 8'h4B, 8'd11, 8'd12, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 8'd5,  1'b1, 1'b0, 8'h4B, 8'd11, 8'd12, 1'b1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].br, vecs[i].tgt, vecs[i].hlt);
      checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expInstr,
               vecs[i].expPc, vecs[i].expAddr, vecs[i].expHalted, 1'b0);
    end

    // Halted stage ignores ready, branches and further halts
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      checkAll($sformatf("halt%0d", i), 1'b0, 8'h4B, 8'd11, 8'd12, 1'b1, 1'b0);
    end

    // Reset leaves HALTED, then reset mid-stream discards the live instruction
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    checkAll("rstHalt", 1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("preRst", 1'b1, 8'h22, 8'd1, 8'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("midRst", 1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0);

`ifdef FETCH_BOUNDS_CHECK_EN
    // Sequential run up to the last valid address, then a fault
    for (int i = 0; i <= 21; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      checkAll($sformatf("seq%0d", i), 1'b1, presetMem(i), 8'(i), 8'(i + 1), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("fault", 1'b0, presetMem(21), 8'd21, 8'd22, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("faultSticky", 1'b0, presetMem(21), 8'd21, 8'd22, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    checkAll("faultRst", 1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd30, 1'b0);
    checkAll("brOut", 1'b0, 8'h00, 8'd0, 8'd30, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("brFault", 1'b0, 8'h00, 8'd0, 8'd30, 1'b1, 1'b1);
`else
    // Branch to the top address, then sequential fetch wraps to zero
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd255, 1'b0);
    checkAll("br255", 1'b0, 8'h00, 8'd0, 8'd255, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("at255", 1'b1, 8'h3F, 8'd255, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("wrap0", 1'b1, 8'h11, 8'd0, 8'd1, 1'b0, 1'b0);
`endif

    // Randomized traffic against the reference model
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    checkAll("rndRst", mValid, mInstr, mOpc, mPc, mHalted, mFault);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 59) == 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 9) == 0),
                    BoundsOn ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 79) == 0));
      checkAll($sformatf("rnd%0d", i), mValid, mInstr, mOpc, mPc, mHalted, mFault);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the NanoRisc core, sitting directly upstream of the instruction memory and directly downstream-feeding the decode/control unit. Owns the program counter, drives the memory address, captures the returned 8-bit instruction into an instruction register, and presents it to decode with a valid/ready handshake. Handles stalls, taken-branch redirects with squash, and halt.

## Interface
- ADDR_WIDTH, 8, program-counter / memory address width
- DATA_WIDTH, 8, instruction width
- RESET_PC, 0, PC value loaded on reset
- PROG_LAST, 21, last valid program address (used only with bounds check)

- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- outAddress  output  ADDR_WIDTH  fetch address to instruction memory (= PC)
- inInstruction  input  DATA_WIDTH  instruction data returned by instruction memory
- outInstruction  output  DATA_WIDTH  instruction register to decode
- outPC  output  ADDR_WIDTH  address of the instruction in outInstruction
- outValid  output  1  outInstruction holds a live instruction
- inReady  input  1  decode accepts outInstruction this cycle
- inBranchTaken  input  1  redirect request
- inBranchTarget  input  ADDR_WIDTH  redirect address
- inHalt  input  1  stop fetching
- outHalted  output  1  block is in HALTED
- outFault  output  1  fetch beyond PROG_LAST (bounds check only)

## Operation
- States: RUN, REDIRECT, HALTED.
- Reset: PC=RESET_PC, outInstruction=0, outPC=0, outValid=0, outHalted=0, outFault=0, state=RUN.
- outAddress is combinationally PC; memory samples it at the negedge inside the same cycle.
- Accept = outValid & inReady. Load = !outValid | inReady.
- RUN, Load: outInstruction<=inInstruction, outPC<=PC, outValid<=1, PC<=PC+1.
- RUN, !Load (stall): PC, outInstruction, outPC, outValid held.
- inBranchTaken (any state but HALTED, regardless of inReady): PC<=inBranchTarget, outValid<=0 (squashes in-flight sequential fetch), state=REDIRECT.
- REDIRECT: one bubble cycle; next posedge captures instruction at target as RUN-Load, state=RUN.
- inHalt: state=HALTED, outValid<=0, PC frozen, outHalted=1; only reset exits.
- Priority: reset > inHalt > inBranchTaken > stall > normal advance.
- PC arithmetic modulo 2^ADDR_WIDTH: 255+1 wraps to 0.

## Timing
- Address-to-valid latency: 1 cycle (PC at cycle n, outValid with that instruction after posedge ending n).
- Throughput: 1 instruction/cycle while inReady=1.
- Branch penalty: exactly 1 bubble cycle (outValid=0) after the redirect edge.
- Stall releases with no lost or duplicated instruction: memory keeps reading the held PC.
- Reset asserted mid-stream: next posedge applies reset values, in-flight instruction discarded.
- inBranchTaken and inHalt same cycle: halt wins, target ignored.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined: on a Load with PC > PROG_LAST, no instruction captured, outValid<=0, outFault<=1 (sticky until reset), state=HALTED. Branch to target > PROG_LAST faults on the following fetch cycle.
- Not defined: no check; PC wraps freely; outFault tied 0; PROG_LAST unused.

## Structure
- Shared package nanorisc_pkg: state enum (RUN, REDIRECT, HALTED), ADDR_WIDTH/DATA_WIDTH defaults, RESET_PC constant.
- One sub-module: fetch_pc — PC register with next-PC mux (hold / +1 / target / reset), instantiated once in fetch_unit.

## Test plan
- Reset, memory preloaded 0x11,0x22,0x33, inReady=1 -> outValid rises after first posedge; outInstruction 0x11,0x22,0x33 with outPC 0,1,2 on consecutive cycles.
- inReady=0 for 3 cycles while outInstruction=0x22 -> 0x22/outPC=1 held, outAddress=2; release -> next 0x33, no duplicates.
- inBranchTaken with target 10 while outPC=2 -> one cycle outValid=0, then outPC=10 with memory[10].
- inHalt asserted -> outHalted=1, outValid=0, outAddress frozen for 20 cycles; simultaneous branch ignored; reset restores PC=0.
- PC forced to 255 via branch, bounds check off -> fetches 255 then 0.
- FETCH_BOUNDS_CHECK_EN, PROG_LAST=21, sequential run -> last valid outPC=21, then outFault=1, outHalted=1, outValid=0.
